// File: rtl/uart_tx_periph.sv
// uart_tx_periph: memory-mapped 8N1 console transmitter
// with a byte FIFO, programmable baud divisor and drain interrupt.
module uart_tx_periph #(
  parameter int FIFO_DEPTH  = 8,
  parameter int DIV_WIDTH   = 16,
  parameter int DEFAULT_DIV = 868
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en_i,
  input  logic [3:0]  we_i,
  input  logic [3:0]  addr_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        tx_o,
  output logic        irq_o
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [PW-1:0] P1 = PW'(1);
  localparam logic [CW-1:0] C1 = CW'(1);
  localparam logic [CW-1:0] CFULL = CW'(FIFO_DEPTH);
  localparam logic [DIV_WIDTH-1:0] D1 = DIV_WIDTH'(1);
  localparam logic [DIV_WIDTH-1:0] DRST =
    DIV_WIDTH'(DEFAULT_DIV);

  typedef enum logic [1:0] {
    S_IDLE, S_START, S_DATA, S_STOP
  } state_t;

  state_t               r_state;
  logic [7:0]           r_mem [FIFO_DEPTH];
  logic [PW-1:0]        r_wr_ptr;
  logic [PW-1:0]        r_rd_ptr;
  logic [CW-1:0]        r_count;
  logic                 r_ovf;
  logic                 r_irqen;
  logic                 r_irq;
  logic                 r_tx;
  logic [DIV_WIDTH-1:0] r_div;
  logic [DIV_WIDTH-1:0] r_bitdiv;
  logic [DIV_WIDTH-1:0] r_cnt;
  logic [7:0]           r_shift;
  logic [2:0]           r_bit;
  logic [31:0]          r_rdata;

  logic                 w_empty;
  logic                 w_full;
  logic                 w_busy;
  logic                 w_pop;
  logic                 w_push_req;
  logic                 w_push;
  logic                 w_wr;
  logic [1:0]           w_sel;
  logic [DIV_WIDTH-1:0] w_bdiv;
  logic [31:0]          w_rmux;
  logic                 w_unused;

  assign w_sel      = addr_i[3:2];
  assign w_wr       = en_i & (we_i != 4'h0);
  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == CFULL);
  assign w_busy     = (r_state != S_IDLE);
  // The serializer takes a byte when idle or at the last stop cycle.
  assign w_pop      = !w_empty &
                      ((r_state == S_IDLE) |
                       ((r_state == S_STOP) & (r_cnt == '0)));
  assign w_push_req = en_i & we_i[0] & (w_sel == 2'd0);
  assign w_push     = w_push_req & (!w_full | w_pop);
  assign w_bdiv     = (r_div == '0) ? D1 : r_div;
  assign w_unused   = ^{addr_i[1:0], data_i};

  assign data_o = r_rdata;
  assign tx_o   = r_tx;
  assign irq_o  = r_irq;

  always_comb begin
    w_rmux = '0;
    unique case (w_sel)
      2'd1: w_rmux = {16'h0, 8'(r_count), 4'h0,
                      r_ovf, w_busy, w_empty, w_full};
      2'd2: w_rmux = 32'(r_div);
      2'd3: w_rmux = {31'h0, r_irqen};
      default: w_rmux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
      r_div    <= DRST;
      r_irqen  <= 1'b0;
      r_rdata  <= '0;
      r_irq    <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + P1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + P1;
      if (w_push & !w_pop)
        r_count <= r_count + C1;
      else if (!w_push & w_pop)
        r_count <= r_count - C1;
      if (w_push_req & !w_push)
        r_ovf <= 1'b1;
      else if (w_wr & (w_sel == 2'd1) & data_i[3])
        r_ovf <= 1'b0;
      if (w_wr & (w_sel == 2'd2))
        r_div <= data_i[DIV_WIDTH-1:0];
      if (w_wr & (w_sel == 2'd3))
        r_irqen <= data_i[0];
      r_rdata <= (en_i & (we_i == 4'h0)) ? w_rmux : '0;
      r_irq   <= r_irqen & w_empty & !w_busy;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= data_i[7:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_tx     <= 1'b1;
      r_shift  <= '0;
      r_bit    <= '0;
      r_cnt    <= '0;
      r_bitdiv <= D1;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_shift  <= r_mem[r_rd_ptr];
            r_bitdiv <= w_bdiv;
            r_cnt    <= w_bdiv - D1;
            r_tx     <= 1'b0;
            r_state  <= S_START;
          end
        end
        S_START: begin
          if (r_cnt == '0) begin
            r_tx    <= r_shift[0];
            r_shift <= r_shift >> 1;
            r_bit   <= '0;
            r_cnt   <= r_bitdiv - D1;
            r_state <= S_DATA;
          end else begin
            r_cnt <= r_cnt - D1;
          end
        end
        S_DATA: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - D1;
          end else if (r_bit == 3'd7) begin
            r_tx    <= 1'b1;
            r_cnt   <= r_bitdiv - D1;
            r_state <= S_STOP;
          end else begin
            r_tx    <= r_shift[0];
            r_shift <= r_shift >> 1;
            r_bit   <= r_bit + 3'd1;
            r_cnt   <= r_bitdiv - D1;
          end
        end
        S_STOP: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - D1;
          end else if (w_pop) begin
            r_shift  <= r_mem[r_rd_ptr];
            r_bitdiv <= w_bdiv;
            r_cnt    <= w_bdiv - D1;
            r_tx     <= 1'b0;
            r_state  <= S_START;
          end else begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule
